// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the stall/flush scheduler.
// master = stage side (raises requests), slave = pipe_ctrl (drives hold/clear/redirect).
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              rdy_in;
    logic              if_stall_req;
    logic              id_stall_req;
    logic              mem_stall_req;
    logic              ex_mispredict;
    logic [ADDR_W-1:0] ex_target;
    logic [4:0]        stall;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rdy_in, if_stall_req, id_stall_req, mem_stall_req, ex_mispredict, ex_target,
        input  stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc, stall_cnt, flush_cnt
    );

    modport slave (
        input  rdy_in, if_stall_req, id_stall_req, mem_stall_req, ex_mispredict, ex_target,
        output stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush scheduler with a RUN/PEND FSM that defers a mispredict
// redirect while MEM stalls. Optional perf counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic           clk_in,
    input  logic           rst_in,
    pipe_ctrl_if.slave     bus
);
    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_next_pend_pc;

    logic [4:0]        w_stall;
    logic              w_flush_if_id;
    logic              w_flush_id_ex;
    logic              w_redirect_valid;
    logic [ADDR_W-1:0] w_redirect_pc;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= RUN;
            r_pend_pc <= '0;
        end else if (bus.rdy_in) begin
            r_state   <= w_next_state;
            r_pend_pc <= w_next_pend_pc;
        end
    end

    // A redirect is latched only from RUN, so a repeating mispredict from a frozen EX
    // cannot overwrite the pending target or cause a second redirect.
    always_comb begin
        w_next_state   = r_state;
        w_next_pend_pc = r_pend_pc;
        if (bus.mem_stall_req) begin
            if (r_state == RUN && bus.ex_mispredict) begin
                w_next_state   = PEND;
                w_next_pend_pc = bus.ex_target;
            end
        end else if (r_state == PEND) begin
            w_next_state = RUN;
        end
    end

    always_comb begin
        w_stall          = 5'b00000;
        w_flush_if_id    = 1'b0;
        w_flush_id_ex    = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        if (rst_in) begin
            w_stall       = 5'b11111;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (!bus.rdy_in || bus.mem_stall_req) begin
            w_stall = 5'b11111;
        end else if (r_state == PEND) begin
            w_redirect_valid = 1'b1;
            w_redirect_pc    = r_pend_pc;
            w_flush_if_id    = 1'b1;
            w_flush_id_ex    = 1'b1;
        end else if (bus.ex_mispredict) begin
            w_redirect_valid = 1'b1;
            w_redirect_pc    = bus.ex_target;
            w_flush_if_id    = 1'b1;
            w_flush_id_ex    = 1'b1;
        end else if (bus.id_stall_req) begin
            w_stall       = 5'b00011;
            w_flush_id_ex = 1'b1;
        end else if (bus.if_stall_req) begin
            w_stall       = 5'b00001;
            w_flush_if_id = 1'b1;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.flush_if_id    = w_flush_if_id;
    assign bus.flush_id_ex    = w_flush_id_ex;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.rdy_in) begin
            if (|w_stall)         r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect_valid) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule
